// File: rtl/morse_symbol_tx.sv
// -----------------------------------------------------------------------------
// morse_symbol_tx
//
// Purpose
//   Serialises the Morse pattern of one hex digit (0-F) onto a single keyed
//   line that drives an LED or buzzer. The digit arrives one-hot from the
//   upstream 4-to-16 decoder. The block times dots, dashes, the gap between
//   elements and the trailing inter-character gap, and it talks to the
//   upstream controller through a start/done handshake.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   simbolo       in  16   one-hot symbol select; bit k selects hex digit k
//   inicio        in   1   start strobe, sampled on a rising clk edge
//   ocupado       out  1   high while a character (including its gap) runs
//   salida_morse  out  1   keyed line; 1 = mark, 0 = space
//   fin           out  1   one-cycle pulse when the character has finished
//   error         out  1   one-cycle pulse when inicio is taken with a
//                          zero or multi-hot simbolo
//   tono          out  1   buzzer tone, only with MORSE_TONE_EN defined
//
// Build option
//   MORSE_TONE_EN  adds the tono output and its tone counter. When the macro
//                  is undefined, neither exists.
//
// Handshake
//   inicio is accepted only while the FSM is in IDLE. That includes the cycle
//   in which fin is high, so characters can run back to back. While ocupado
//   is high, inicio is ignored and is not queued. simbolo is looked at only in
//   the accepting cycle.
//
// Timing
//   All outputs come from flops loaded with the next-state decode. The first
//   mark therefore appears in the cycle right after the accepting edge. The
//   unit timer counts down to zero and is reloaded on every state change.
// -----------------------------------------------------------------------------
module morse_symbol_tx #(
    parameter int UNIT_CYCLES = 25000000
`ifdef MORSE_TONE_EN
    ,
    parameter int TONE_HALF   = 50000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] simbolo,
    input  logic        inicio,
    output logic        ocupado,
    output logic        salida_morse,
    output logic        fin,
    output logic        error
`ifdef MORSE_TONE_EN
    ,
    output logic        tono
`endif
);

    // Unit timer width. It is derived from UNIT_CYCLES and is not meant to be
    // overridden.
    localparam int CNT_W = $clog2(3 * UNIT_CYCLES + 1);

    // Reload values. The timer sits in a state for load+1 cycles.
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MARK     = 2'd1,
        GAP      = 2'd2,
        CHAR_GAP = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q,   idx_d;     // element index, 0 = first sent
    logic [4:0]       pat_q,   pat_d;     // left-aligned: bit 4 is element 0
    logic [2:0]       len_q,   len_d;     // number of elements, 1..5

    logic             salida_q, salida_d;
    logic             ocupado_q, ocupado_d;
    logic             fin_q,    fin_d;
    logic             error_q,  error_d;

    // -------------------------------------------------------------------------
    // Symbol decode: one-hot check and bit position
    // -------------------------------------------------------------------------
    logic       sym_onehot;
    logic [3:0] sym_idx;

    // x & (x-1) clears the lowest set bit. The result is zero only when at
    // most one bit was set, and the != 0 term rejects the empty case.
    assign sym_onehot = (simbolo != 16'd0) &&
                        ((simbolo & (simbolo - 16'd1)) == 16'd0);

    always_comb begin
        sym_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (simbolo[i]) begin
                sym_idx = 4'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pattern ROM. Patterns are left-aligned so the first element sent is
    // always bit 4, whatever the length. 1 = dash, 0 = dot.
    // -------------------------------------------------------------------------
    logic [4:0] rom_pat;
    logic [2:0] rom_len;

    always_comb begin
        rom_pat = 5'b00000;
        rom_len = 3'd1;
        unique case (sym_idx)
            4'h0: begin rom_pat = 5'b11111; rom_len = 3'd5; end // -----
            4'h1: begin rom_pat = 5'b01111; rom_len = 3'd5; end // .----
            4'h2: begin rom_pat = 5'b00111; rom_len = 3'd5; end // ..---
            4'h3: begin rom_pat = 5'b00011; rom_len = 3'd5; end // ...--
            4'h4: begin rom_pat = 5'b00001; rom_len = 3'd5; end // ....-
            4'h5: begin rom_pat = 5'b00000; rom_len = 3'd5; end // .....
            4'h6: begin rom_pat = 5'b10000; rom_len = 3'd5; end // -....
            4'h7: begin rom_pat = 5'b11000; rom_len = 3'd5; end // --...
            4'h8: begin rom_pat = 5'b11100; rom_len = 3'd5; end // ---..
            4'h9: begin rom_pat = 5'b11110; rom_len = 3'd5; end // ----.
            4'hA: begin rom_pat = 5'b01000; rom_len = 3'd2; end // .-
            4'hB: begin rom_pat = 5'b10000; rom_len = 3'd4; end // -...
            4'hC: begin rom_pat = 5'b10100; rom_len = 3'd4; end // -.-.
            4'hD: begin rom_pat = 5'b10000; rom_len = 3'd3; end // -..
            4'hE: begin rom_pat = 5'b00000; rom_len = 3'd1; end // .
            4'hF: begin rom_pat = 5'b00100; rom_len = 3'd4; end // ..-.
            default: begin rom_pat = 5'b00000; rom_len = 3'd1; end
        endcase
    end

    // -------------------------------------------------------------------------
    // Element lookup. Shifting the latched pattern left by an index moves
    // that element into bit 4.
    // -------------------------------------------------------------------------
    logic [2:0] idx_inc;
    logic [4:0] pat_next_sh;
    logic       next_is_dash;
    logic       last_elem;

    assign idx_inc      = idx_q + 3'd1;
    assign pat_next_sh  = pat_q << idx_inc;
    assign next_is_dash = pat_next_sh[4];
    assign last_elem    = (idx_q == 3'(len_q - 3'd1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= 3'd0;
            pat_q     <= 5'd0;
            len_q     <= 3'd0;
            salida_q  <= 1'b0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            salida_q  <= salida_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
            error_q   <= error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fin_d   = 1'b0;
        error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inicio) begin
                    if (sym_onehot) begin
                        pat_d   = rom_pat;
                        len_d   = rom_len;
                        idx_d   = 3'd0;
                        timer_d = rom_pat[4] ? DASH_LOAD : DOT_LOAD;
                        state_d = MARK;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            MARK: begin
                if (timer_q == '0) begin
                    if (last_elem) begin
                        timer_d = DASH_LOAD;   // inter-character gap is 3 units
                        state_d = CHAR_GAP;
                    end else begin
                        timer_d = DOT_LOAD;
                        state_d = GAP;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            GAP: begin
                if (timer_q == '0) begin
                    idx_d   = idx_inc;
                    timer_d = next_is_dash ? DASH_LOAD : DOT_LOAD;
                    state_d = MARK;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            CHAR_GAP: begin
                if (timer_q == '0) begin
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Level outputs are registered copies of the next-state decode, so
        // they line up exactly with the state they describe.
        salida_d  = (state_d == MARK);
        ocupado_d = (state_d != IDLE);
    end

    assign salida_morse = salida_q;
    assign ocupado      = ocupado_q;
    assign fin          = fin_q;
    assign error        = error_q;

`ifdef MORSE_TONE_EN
    // -------------------------------------------------------------------------
    // Buzzer tone. The counter restarts at every new mark, so each mark
    // begins with tono low. The tone is held low in every non-mark state.
    // -------------------------------------------------------------------------
    localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tono_q,     tono_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt_q <= '0;
            tono_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tono_q     <= tono_d;
        end
    end

    always_comb begin
        tone_cnt_d = tone_cnt_q;
        tono_d     = tono_q;
        if (state_d != MARK) begin
            tone_cnt_d = '0;
            tono_d     = 1'b0;
        end else if (state_q != MARK) begin
            tone_cnt_d = '0;
            tono_d     = 1'b0;
        end else if (tone_cnt_q == TONE_W'(TONE_HALF - 1)) begin
            tone_cnt_d = '0;
            tono_d     = ~tono_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
        end
    end

    assign tono = tono_q;
`endif

endmodule

// File: tb/tb_morse_symbol_tx.sv
// -----------------------------------------------------------------------------
// tb_morse_symbol_tx
//   Testbench for morse_symbol_tx, built with UNIT_CYCLES = 4. A cycle-level
//   reference waveform for each character is built from the Morse text
//   ("-", ".") of the digit and compared against the DUT in every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_morse_symbol_tx;

  localparam int UNIT = 4;

  logic        clk;
  logic        rst;
  logic [15:0] simbolo;
  logic        inicio;
  logic        ocupado;
  logic        salida_morse;
  logic        fin;
  logic        error;
`ifdef MORSE_TONE_EN
  logic        tono;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // expected salida_morse level, one entry per cycle starting at cycle 1
  logic exp_q[$];

  string morse_txt[16] = '{"-----", ".----", "..---", "...--", "....-",
                           ".....", "-....", "--...", "---..", "----.",
                           ".-", "-...", "-.-.", "-..", ".", "..-."};

  morse_symbol_tx #(.UNIT_CYCLES(UNIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .simbolo      (simbolo),
    .inicio       (inicio),
    .ocupado      (ocupado),
    .salida_morse (salida_morse),
    .fin          (fin),
    .error        (error)
`ifdef MORSE_TONE_EN
    ,
    .tono         (tono)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // dot = 1 unit high, dash = 3 units high, 1 unit low between elements,
  // 3 units low after the last element
  task automatic build_exp(input int d);
    int n;
    exp_q.delete();
    n = morse_txt[d].len();
    for (int i = 0; i < n; i++) begin
      int mark_len;
      mark_len = (morse_txt[d].getc(i) == "-") ? 3 * UNIT : UNIT;
      repeat (mark_len) exp_q.push_back(1'b1);
      if (i != n - 1) repeat (UNIT) exp_q.push_back(1'b0);
    end
    repeat (3 * UNIT) exp_q.push_back(1'b0);
  endtask

  function automatic logic [15:0] rand_sym();
    return 16'($urandom);
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; the following posedge samples the start.
  task automatic drive_start(input logic [15:0] sym);
    inicio  = 1'b1;
    simbolo = sym;
  endtask

  // Follows one character from its first mark cycle through the fin cycle.
  // ign_cyc > 0 pulses an (ignored) inicio in that cycle. With chain set, a
  // new start is driven in the fin cycle.
  task automatic expect_char(input int d, input int ign_cyc,
                             input bit chain, input logic [15:0] next_sym);
    int len;
    build_exp(d);
    len = exp_q.size();
    for (int n = 1; n <= len + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n <= len) begin
        chk($sformatf("salida d%0h c%0d", d, n), salida_morse, exp_q[n-1]);
        chk($sformatf("ocupado d%0h c%0d", d, n), ocupado, 1'b1);
        chk($sformatf("fin d%0h c%0d", d, n), fin, 1'b0);
      end else begin
        chk($sformatf("fin_pulse d%0h", d), fin, 1'b1);
        chk($sformatf("fin_ocupado d%0h", d), ocupado, 1'b0);
        chk($sformatf("fin_salida d%0h", d), salida_morse, 1'b0);
      end
      chk($sformatf("error d%0h c%0d", d, n), error, 1'b0);
      // drive inputs for the next edge
      if (n == ign_cyc) begin
        inicio  = 1'b1;
        simbolo = rand_sym();
      end else if (n == len + 1 && chain) begin
        drive_start(next_sym);
      end else begin
        inicio  = 1'b0;
        simbolo = rand_sym();
      end
    end
    if (!chain) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_fin d%0h", d), fin, 1'b0);
      chk($sformatf("post_ocupado d%0h", d), ocupado, 1'b0);
    end
  endtask

  task automatic err_case(input logic [15:0] sym);
    drive_start(sym);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      chk($sformatf("err_pulse %h c%0d", sym, n), error, (n == 1) ? 1'b1 : 1'b0);
      chk($sformatf("err_ocupado %h c%0d", sym, n), ocupado, 1'b0);
      chk($sformatf("err_salida %h c%0d", sym, n), salida_morse, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    inicio  = 1'b0;
    simbolo = 16'h0000;

    // reset state, with a valid start pulled high to show it has no effect
    repeat (2) @(negedge clk);
    drive_start(16'h0001);
    repeat (2) begin
      @(negedge clk);
      chk("rst_salida", salida_morse, 1'b0);
      chk("rst_ocupado", ocupado, 1'b0);
      chk("rst_fin", fin, 1'b0);
      chk("rst_error", error, 1'b0);
    end
    inicio = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    chk("idle_ocupado", ocupado, 1'b0);

    // directed characters: E, 0, A
    drive_start(16'h4000);
    expect_char(14, 0, 1'b0, 16'h0);
    drive_start(16'h0001);
    expect_char(0, 0, 1'b0, 16'h0);
    drive_start(16'h0400);
    expect_char(10, 0, 1'b0, 16'h0);

    // bad symbols
    err_case(16'h0003);
    err_case(16'h0000);
    err_case(16'h8001);

    // A with an ignored inicio at cycle 10, then 0 started on the fin cycle
    drive_start(16'h0400);
    expect_char(10, 10, 1'b1, 16'h0001);
    expect_char(0, 0, 1'b0, 16'h0);

    // random digits, some chained and some with ignored starts
    begin
      int d, nd;
      bit ch;
      d = $urandom_range(0, 15);
      drive_start(16'(1) << d);
      for (int k = 0; k < 10; k++) begin
        ch = (k != 9) && ($urandom_range(0, 1) == 1);
        nd = $urandom_range(0, 15);
        expect_char(d, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0,
                    ch, 16'(1) << nd);
        if (!ch && k != 9) begin
          drive_start(16'(1) << nd);
        end
        d = nd;
      end
    end

    // asynchronous reset in cycle 6 of a '0'
    drive_start(16'h0001);
    build_exp(0);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      chk($sformatf("pre_rst salida c%0d", n), salida_morse, exp_q[n-1]);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_salida", salida_morse, 1'b0);
    chk("async_rst_ocupado", ocupado, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_fin", fin, 1'b0);
    end
    rst = 1'b0;
    for (int n = 0; n < 3 * UNIT + 2; n++) begin
      @(negedge clk);
      chk("after_rst_fin", fin, 1'b0);
      chk("after_rst_ocupado", ocupado, 1'b0);
      chk("after_rst_salida", salida_morse, 1'b0);
    end
    drive_start(16'h0001);
    expect_char(0, 0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
